bht_update_ctrl: RTL and testbench
==================================

// Module: bht_update_ctrl
// PURPOSE
//  Sequencer for a single-ported M-entry table of N-bit saturating predictor counters.
//  Runs a post-reset init sweep, then shares the port between fetch-side lookups and
//  queued resolved-branch updates. Updates are read-modify-write.
//  Sits between fetch/execute and the counter table.
// PARAMETERS
//  M       64  number of table entries (power of 2)
//  N       2   counter width (1 or 2)
//  QDEPTH  4   update queue depth (power of 2, >=2)
//  AW      $clog2(M) (localparam) table address width
// PORTS
//  clk            in   1        clock, all logic on posedge
//  reset          in   1        synchronous, active-low reset
//  lk_valid       in   1        lookup request
//  lk_pc          in   9        lookup PC; index = lk_pc[AW-1:0]
//  lk_ready       out  1        lookup accepted this cycle when lk_valid & lk_ready
//  lk_pred_valid  out  1        prediction valid (1 cycle after accept)
//  lk_pred        out  1        prediction, 1 = taken
//  up_valid       in   1        resolved-branch update request
//  up_pc          in   9        update PC; index = up_pc[AW-1:0]
//  up_taken       in   1        resolved outcome
//  up_ready       out  1        queue can accept (not full and init done)
//  tbl_en         out  1        table port enable
//  tbl_we         out  1        table write enable (valid only with tbl_en)
//  tbl_addr       out  AW       table address
//  tbl_wdata      out  N        table write data
//  tbl_rdata      in   N        table read data, valid the cycle after tbl_en & !tbl_we
//  init_busy      out  1        init sweep in progress
//  q_count        out  $clog2(QDEPTH+1)  update queue occupancy
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=INIT, sweep ptr=0, queue flushed.
//   - Outputs: lk_ready=0, lk_pred_valid=0, lk_pred=0, up_ready=0, tbl_en=0, tbl_we=0,
//     tbl_addr=0, tbl_wdata=0, q_count=0, init_busy=1.
//   - Reset mid-operation aborts any RMW; no partial write completes.
//  FSM states: INIT, IDLE, UPD_RD, UPD_WR.
//  INIT:
//   - One write per cycle: addr 0..M-1, wdata = WEAK_NT (N=2: 2'b01; N=1: 1'b0).
//   - After the write of M-1 -> IDLE.
//   - init_busy drops the same cycle IDLE is entered: M cycles after reset release.
//   - lk_ready=0 and up_ready=0 throughout INIT.
//  IDLE, port arbitration each cycle:
//   1. q_count==QDEPTH -> update wins: issue read of head index, go to UPD_RD, lk_ready=0.
//   2. else if lk_valid -> lk_ready=1; tbl_en=1, tbl_we=0, tbl_addr=lk index.
//      Next cycle: lk_pred_valid=1, lk_pred=tbl_rdata[N-1]; otherwise lk_pred_valid=0.
//   3. else if q_count>0 -> read head index, go to UPD_RD.
//  UPD_RD (rdata arriving):
//   - Next counter = taken ? sat_inc(rdata) : sat_dec(rdata).
//   - Saturation: max (2^N)-1, min 0; no wrap.
//   - Drive tbl_en=1, tbl_we=1, same addr -> UPD_WR.
//  UPD_WR:
//   - Pop head, q_count decremented; -> IDLE.
//   - Port busy 3 cycles per update (read, write, pop); lk_ready=0 in UPD_RD and UPD_WR.
//  Queue:
//   - Push on up_valid & up_ready; up_ready = (state!=INIT) & (q_count<QDEPTH).
//   - Push and pop in the same cycle -> q_count unchanged.
//   - Pointers wrap modulo QDEPTH.
//   - Entries drain in FIFO order.
//  Hazards:
//   - No forwarding: a lookup reads the table value and ignores queued updates
//     to the same index.
//   - Two queued updates to the same index apply sequentially; the second RMW reads
//     the first one's written value.
// TESTING
//  T1 release reset -> 64 writes, addr 0..63, wdata 2'b01; init_busy=0 at cycle 64; ready low before.
//  T2 after init, lookup pc=9'h005 -> tbl_addr=5 read; next cycle lk_pred_valid=1, lk_pred=0.
//  T3 3x update pc=5 taken -> writes 2'b10, 2'b11, 2'b11 (saturate); lookup pc=5 -> lk_pred=1;
//     then 4x not-taken -> writes 10, 01, 00, 00.
//  T4 lk_valid held high, push 4 updates -> q_count=4, up_ready=0; next IDLE cycle lk_ready=0
//     and update RMW issues.
//  T5 push concurrent with UPD_WR pop at q_count=2 -> q_count stays 2; FIFO order preserved
//     across pointer wrap.
//  T6 assert reset during UPD_RD -> no write issued; q_count=0; re-init sweep repeats T1.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl
//   Sequencer for a single-ported table of M saturating N-bit branch predictor
//   counters. After reset it sweeps every entry to weakly-not-taken, then
//   arbitrates the table port between fetch lookups and a small FIFO of
//   resolved-branch updates, each applied as a read-modify-write.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   INIT   | writing WEAK_NT to entry ptr, one entry per cycle
//   IDLE   | port free: serve full queue, else lookup, else queue head
//   UPD_RD | head counter arriving on tbl_rdata, write updated value
//   UPD_WR | write done, pop head from queue
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   lk_valid/lk_pc        lookup request, index = lk_pc[AW-1:0]
//   lk_ready              lookup accepted this cycle
//   lk_pred_valid/lk_pred prediction one cycle after accept (1 = taken)
//   up_valid/up_pc/up_taken  resolved-branch update request
//   up_ready              queue can accept an update
//   tbl_en/tbl_we/tbl_addr/tbl_wdata/tbl_rdata  counter table port
//   init_busy             init sweep in progress
//   q_count               update queue occupancy
module bht_update_ctrl #(
  parameter int M      = 64,
  parameter int N      = 2,
  parameter int QDEPTH = 4,
  localparam int AW    = $clog2(M),
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lk_valid,
  input  logic [8:0]    lk_pc,
  output logic          lk_ready,
  output logic          lk_pred_valid,
  output logic          lk_pred,
  input  logic          up_valid,
  input  logic [8:0]    up_pc,
  input  logic          up_taken,
  output logic          up_ready,
  output logic          tbl_en,
  output logic          tbl_we,
  output logic [AW-1:0] tbl_addr,
  output logic [N-1:0]  tbl_wdata,
  input  logic [N-1:0]  tbl_rdata,
  output logic          init_busy,
  output logic [CW-1:0] q_count
);

  localparam int QW = $clog2(QDEPTH);
  localparam logic [N-1:0] WEAK_NT = (N == 1) ? '0 : N'(1);

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] q_idx [QDEPTH];
  logic          q_tkn [QDEPTH];
  logic [QW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          pv_q;

  logic          en_c, we_c, lk_rdy_c, pop;
  logic [AW-1:0] addr_c;
  logic [N-1:0]  wdata_c;
  logic          push;
  logic [AW-1:0] head_idx;
  logic          head_tkn;
  logic          unused_pc_hi;

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] c);
    return (&c) ? c : c + N'(1);
  endfunction

  function automatic logic [N-1:0] sat_dec(input logic [N-1:0] c);
    return (c == '0) ? c : c - N'(1);
  endfunction

  assign head_idx     = q_idx[rd_ptr];
  assign head_tkn     = q_tkn[rd_ptr];
  assign unused_pc_hi = ^{lk_pc[8:AW], up_pc[8:AW]};

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    lk_rdy_c  = 1'b0;
    pop       = 1'b0;
    case (state)
      INIT: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = ptr;
        wdata_c = WEAK_NT;
        if (ptr == AW'(M - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        // A full queue must drain even under continuous lookups.
        if (cnt == CW'(QDEPTH)) begin
          en_c      = 1'b1;
          addr_c    = head_idx;
          state_nxt = UPD_RD;
        end else if (lk_valid) begin
          lk_rdy_c = 1'b1;
          en_c     = 1'b1;
          addr_c   = lk_pc[AW-1:0];
        end else if (cnt != '0) begin
          en_c      = 1'b1;
          addr_c    = head_idx;
          state_nxt = UPD_RD;
        end
      end
      UPD_RD: begin
        en_c      = 1'b1;
        we_c      = 1'b1;
        addr_c    = head_idx;
        wdata_c   = head_tkn ? sat_inc(tbl_rdata) : sat_dec(tbl_rdata);
        state_nxt = UPD_WR;
      end
      UPD_WR: begin
        pop       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Port outputs are held quiet while reset is low so an interrupted RMW
  // never reaches the table.
  assign tbl_en        = en_c & reset;
  assign tbl_we        = we_c & reset;
  assign tbl_addr      = reset ? addr_c : '0;
  assign tbl_wdata     = reset ? wdata_c : '0;
  assign lk_ready      = lk_rdy_c & reset;
  assign lk_pred_valid = pv_q & reset;
  assign lk_pred       = pv_q & reset & tbl_rdata[N-1];
  assign up_ready      = reset & (state != INIT) & (cnt < CW'(QDEPTH));
  assign init_busy     = ~reset | (state == INIT);
  assign q_count       = cnt;
  assign push          = up_valid & up_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= INIT;
      ptr    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pv_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pv_q  <= lk_valid & lk_rdy_c;
      if (state == INIT) ptr <= ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= up_pc[AW-1:0];
      q_tkn[wr_ptr] <= up_taken;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lk_valid = 1'b0;
  logic [8:0] lk_pc = '0;
  logic       up_valid = 1'b0;
  logic [8:0] up_pc = '0;
  logic       up_taken = 1'b0;
  logic       lk_ready, lk_pred_valid, lk_pred, up_ready;
  logic       tbl_en, tbl_we, init_busy;
  logic [5:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata = '0;
  logic [2:0] q_count;

  always #5 clk = ~clk;

  bht_update_ctrl dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .lk_pred_valid(lk_pred_valid), .lk_pred(lk_pred),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .init_busy(init_busy), .q_count(q_count)
  );

  // counter table device
  logic [1:0] mem [64];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  int cmp_n = 0;
  int fail_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  typedef struct { logic [5:0] idx; logic t; } upd_t;
  upd_t       expq[$];
  logic [1:0] mdl_tbl [64];
  logic [1:0] wr_log[$];
  logic       pred_log[$];
  int         cyc = 0, rst_cyc = 0, exp_cnt = 0;
  bit         in_run = 0, pend = 0, pend_val = 0, wrote_prev = 0;

  always @(negedge clk) begin
    bit   wrote_now, pushed;
    upd_t e;
    int   nv;
    if (!reset) begin
      chk("rst_tbl_en", tbl_en, 0);
      chk("rst_lk_ready", lk_ready, 0);
      chk("rst_up_ready", up_ready, 0);
      chk("rst_init_busy", init_busy, 1);
      if (rst_cyc > 0) begin
        chk("rst_q_count", q_count, 0);
        chk("rst_pred_valid", lk_pred_valid, 0);
        chk("rst_pred", lk_pred, 0);
      end
      rst_cyc++;
      cyc = 0; exp_cnt = 0; expq.delete();
      pend = 0; wrote_prev = 0; in_run = 1;
      for (int i = 0; i < 64; i++) mdl_tbl[i] = 2'b01;
    end else if (in_run) begin
      rst_cyc = 0;
      if (cyc < 64) begin
        chk("init_en", tbl_en, 1);
        chk("init_we", tbl_we, 1);
        chk("init_addr", tbl_addr, cyc);
        chk("init_wdata", tbl_wdata, 2'b01);
        chk("init_lk_ready", lk_ready, 0);
        chk("init_up_ready", up_ready, 0);
        chk("init_busy_hi", init_busy, 1);
      end else begin
        chk("init_busy_lo", init_busy, 0);
        chk("q_count", q_count, exp_cnt);
        chk("up_ready", up_ready, (exp_cnt < 4) ? 1 : 0);
        if (exp_cnt == 4) chk("lk_ready_full", lk_ready, 0);
        chk("pred_valid", lk_pred_valid, pend);
        if (pend) begin
          chk("pred", lk_pred, pend_val);
          pred_log.push_back(lk_pred);
        end
        pend = 0;
        if (lk_valid && lk_ready) begin
          chk("lk_en", tbl_en, 1);
          chk("lk_we", tbl_we, 0);
          chk("lk_addr", tbl_addr, lk_pc[5:0]);
          pend = 1;
          pend_val = mdl_tbl[lk_pc[5:0]][1];
        end
        wrote_now = tbl_en && tbl_we;
        if (wrote_now) begin
          if (expq.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = expq.pop_front();
            nv = mdl_tbl[e.idx];
            nv = e.t ? ((nv < 3) ? nv + 1 : 3) : ((nv > 0) ? nv - 1 : 0);
            chk("upd_addr", tbl_addr, e.idx);
            chk("upd_wdata", tbl_wdata, nv);
            mdl_tbl[e.idx] = 2'(nv);
            wr_log.push_back(tbl_wdata);
          end
        end
        pushed = up_valid && up_ready;
        if (pushed) begin
          e.idx = up_pc[5:0];
          e.t   = up_taken;
          expq.push_back(e);
        end
        exp_cnt = exp_cnt + int'(pushed) - int'(wrote_prev);
        wrote_prev = wrote_now;
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [8:0] pc);
    int n = 0;
    lk_pc = pc; lk_valid = 1'b1;
    @(negedge clk);
    while (!lk_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("lookup_timeout", 0, 1);
    @(posedge clk); #1;
    lk_valid = 1'b0;
  endtask

  task automatic do_push(input logic [8:0] pc, input logic t);
    int n = 0;
    up_pc = pc; up_taken = t; up_valid = 1'b1;
    @(negedge clk);
    while (!up_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (q_count != 0 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("drain_timeout", 0, 1);
    step(2);
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    @(negedge clk);
    while (init_busy && n < 200) begin n++; @(negedge clk); end
    chk(nm, n, 64);
    step(1);
  endtask

  task automatic chk_log(input string nm, input int i, input int exp);
    chk(nm, (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFF, exp);
  endtask

  task automatic chk_pred(input string nm, input int exp);
    chk(nm, (pred_log.size() > 0) ? 32'(pred_log[pred_log.size()-1]) : 32'hFF, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset and init sweep
    step(3);
    reset = 1'b1;
    wait_init("t1_init_cycles");

    // T2: fresh lookup reads weakly-not-taken
    do_lookup(9'h005);
    step(1);
    chk_pred("t2_pred", 0);

    // T3: saturating up then down
    wr_log.delete();
    for (int i = 0; i < 3; i++) do_push(9'h005, 1'b1);
    wait_drain();
    chk("t3_up_n", wr_log.size(), 3);
    chk_log("t3_w0", 0, 2'b10);
    chk_log("t3_w1", 1, 2'b11);
    chk_log("t3_w2", 2, 2'b11);
    do_lookup(9'h105);
    step(1);
    chk_pred("t3_pred_taken", 1);
    wr_log.delete();
    for (int i = 0; i < 4; i++) do_push(9'h005, 1'b0);
    wait_drain();
    chk_log("t3_w3", 0, 2'b10);
    chk_log("t3_w4", 1, 2'b01);
    chk_log("t3_w5", 2, 2'b00);
    chk_log("t3_w6", 3, 2'b00);

    // T4: full queue beats continuous lookups
    wr_log.delete();
    lk_pc = 9'h007; lk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_pc = 9'(10 + i); up_taken = (i % 2 == 0); up_valid = 1'b1;
      step(1);
    end
    up_valid = 1'b0;
    @(negedge clk);
    chk("t4_q_full", q_count, 4);
    chk("t4_up_ready", up_ready, 0);
    chk("t4_lk_ready", lk_ready, 0);
    chk("t4_rd_en", tbl_en, 1);
    chk("t4_rd_we", tbl_we, 0);
    chk("t4_rd_addr", tbl_addr, 10);
    step(4);
    @(negedge clk);
    chk("t4_q_starved", q_count, 3);
    step(1);
    lk_valid = 1'b0;
    wait_drain();
    chk_log("t4_w0", 0, 2'b10);
    chk_log("t4_w1", 1, 2'b00);
    chk_log("t4_w2", 2, 2'b10);
    chk_log("t4_w3", 3, 2'b00);

    // T5: push during pop, pointer wrap, same-index back-to-back RMW
    wr_log.delete();
    up_valid = 1'b1; up_pc = 9'd20; up_taken = 1'b1;
    step(1);
    up_pc = 9'd21; up_taken = 1'b0;
    step(1);
    up_valid = 1'b0;
    step(1);
    up_valid = 1'b1; up_pc = 9'd20; up_taken = 1'b1;
    @(negedge clk);
    chk("t5_pop_cycle_en", tbl_en, 0);
    chk("t5_q_before", q_count, 2);
    step(1);
    up_valid = 1'b0;
    @(negedge clk);
    chk("t5_q_after", q_count, 2);
    wait_drain();
    chk_log("t5_w0", 0, 2'b10);
    chk_log("t5_w1", 1, 2'b00);
    chk_log("t5_w2", 2, 2'b11);
    do_lookup(9'd12);
    step(1);
    chk_pred("t5_pred12", 1);

    // T6: reset during UPD_RD
    do_push(9'd30, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!(tbl_en && !tbl_we) && n < 20) begin n++; @(negedge clk); end
      chk("t6_rd_seen", (n < 20) ? 1 : 0, 1);
    end
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_no_write_en", tbl_en, 0);
    step(2);
    @(negedge clk);
    chk("t6_q_count", q_count, 0);
    chk("t6_init_busy", init_busy, 1);
    chk("t6_mem30", mem[30], 2'b01);
    step(1);
    reset = 1'b1;
    wait_init("t6_reinit_cycles");
    do_lookup(9'd12);
    step(1);
    chk_pred("t6_pred12_reinit", 0);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
